// File: rtl/dma_write_if.sv
// dma_write_if: memory-bus and SPI-master signals of the SD write DMA
interface dma_write_if;
  logic [15:0] iaddr, oaddr;
  logic [3:0] nblocks;
  logic [7:0] idata, ospi_data, ispi_data, debug;
  logic ready, error, ospi_wr, ispi_dsr;
  modport master(
    input iaddr, nblocks, idata, ispi_data, ispi_dsr,
    output oaddr, ready, error, ospi_data, ospi_wr, debug
  );
  modport slave(
    output iaddr, nblocks, idata, ispi_data, ispi_dsr,
    input oaddr, ready, error, ospi_data, ospi_wr, debug
  );
endinterface

// File: rtl/dma_write.sv
// dma_write: streams 512-byte memory blocks to an SD card as SPI data packets
module dma_write #(
  parameter int BLOCK_SIZE = 512,
  parameter int RESP_POLLS = 8,
  parameter logic [15:0] BUSY_LIMIT = 16'hFFFF,
  parameter logic [7:0] START_TOKEN = 8'hFE
) (
  input logic clk,
  input logic reset_n,
  input logic ce,
  dma_write_if.master bus
);
  typedef enum logic [3:0] {
    IDLE, TOKEN, FETCH, LATCH, DATA, CRC1, CRC2, RESP, BUSY, NEXT, DONE
  } state_t;
  localparam logic [9:0] LAST_BYTE = 10'(BLOCK_SIZE - 1);
  localparam logic [15:0] LAST_RESP = 16'(RESP_POLLS - 1);
  localparam logic [15:0] LAST_BUSY = BUSY_LIMIT - 16'd1;
  state_t st;
  logic [1:0] ph;
  logic [9:0] cnt;
  logic [15:0] pc, addr;
  logic [3:0] blk;
  logic [7:0] byte_r, tx, rx;
  assign rx = bus.ispi_data;
  assign tx = (st == TOKEN) ? START_TOKEN : (st == DATA) ? byte_r : 8'hFF;
  assign bus.debug = {bus.ready, bus.error, 2'b00, st};
  // SEND states share ph: 0 = issue on dsr, 1 = guard, 2 = wait for the received byte
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      st <= IDLE;
      ph <= 2'd0;
      cnt <= '0;
      pc <= '0;
      blk <= '0;
      addr <= '0;
      byte_r <= '0;
      bus.ready <= 1'b1;
      bus.error <= 1'b0;
      bus.ospi_wr <= 1'b0;
      bus.ospi_data <= 8'hFF;
      bus.oaddr <= '0;
    end else begin
      bus.ospi_wr <= 1'b0;
      if (ce)
        case (st)
          IDLE:
            if (bus.nblocks != 4'd0) begin
              addr <= bus.iaddr;
              blk <= bus.nblocks;
              bus.ready <= 1'b0;
              bus.error <= 1'b0;
              st <= TOKEN;
            end
          FETCH: begin
            bus.oaddr <= addr;
            st <= LATCH;
          end
          LATCH: begin
            byte_r <= bus.idata;
            st <= DATA;
          end
          NEXT: begin
            blk <= blk - 4'd1;
            st <= (blk == 4'd1) ? DONE : TOKEN;
          end
          DONE: begin
            bus.ready <= 1'b1;
            bus.ospi_data <= 8'hFF;
            st <= IDLE;
          end
          default:
            if (ph == 2'd0) begin
              if (bus.ispi_dsr) begin
                bus.ospi_data <= tx;
                bus.ospi_wr <= 1'b1;
                ph <= 2'd1;
              end
            end else if (ph == 2'd1) ph <= 2'd2;
            else if (bus.ispi_dsr) begin
              ph <= 2'd0;
              case (st)
                TOKEN: begin
                  cnt <= '0;
                  st <= FETCH;
                end
                DATA: begin
                  addr <= addr + 16'd1;
                  cnt <= cnt + 10'd1;
                  st <= (cnt == LAST_BYTE) ? CRC1 : FETCH;
                end
                CRC1: st <= CRC2;
                CRC2: begin
                  pc <= '0;
                  st <= RESP;
                end
                RESP:
                  if (!rx[4]) begin
                    pc <= '0;
                    bus.error <= (rx[4:0] != 5'h05);
                    st <= (rx[4:0] == 5'h05) ? BUSY : DONE;
                  end else if (pc == LAST_RESP) begin
                    bus.error <= 1'b1;
                    st <= DONE;
                  end else pc <= pc + 16'd1;
                BUSY:
                  if (rx != 8'h00) st <= NEXT;
                  else if (pc == LAST_BUSY) begin
                    bus.error <= 1'b1;
                    st <= DONE;
                  end else pc <= pc + 16'd1;
                default: st <= IDLE;
              endcase
            end
        endcase
    end
endmodule

// File: doc/dma_write.md
Name: dma_write

Overview:
- SPI write-side DMA engine for the floppy subsystem; complement of the SD-read DMA.
- Streams 1..15 consecutive 512-byte blocks from workhorse CPU memory to the SD card over the shared SPI master, formatted as SD data packets.
- Handles the start token, dummy CRC, data-response check and card-busy wait.
- While active (ready=0), the CPU is stalled and the DMA owns the memory address bus.

Parameters:
- BLOCK_SIZE, 512, bytes per block.
- RESP_POLLS, 8, max 0xFF polls awaiting the data-response token.
- BUSY_LIMIT, 16'hFFFF, max 0xFF polls while the card holds DO low (busy).
- START_TOKEN, 8'hFE, single-block data token.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, reset: asynchronous, active-low.
- ce, input, 1, clock enable; the FSM advances only on ce=1 cycles.
- iaddr, input, 16, source start address; sampled at start.
- nblocks, input, 4, block count; nonzero while ready=1 starts a transfer.
- oaddr, output, 16, memory read address.
- idata, input, 8, memory read data; valid on the ce cycle after oaddr is presented.
- ready, output, 1, 1 = idle, CPU owns the bus.
- error, output, 1, sticky failure flag; cleared at next start.
- ospi_data, output, 8, byte to the SPI master.
- ospi_wr, output, 1, one-clk SPI write strobe.
- ispi_data, input, 8, byte received by SPI.
- ispi_dsr, input, 1, 1 = SPI idle, last byte complete.
- debug, output, 8, {ready, error, 2'b0, state[3:0]}.

Behaviour:
- Reset (async) values:
  - ready=1, error=0, ospi_wr=0, ospi_data=8'hFF, oaddr=0.
  - State IDLE; counters 0.
  - Asserting reset mid-transfer abandons the transfer immediately; no further strobes are issued.
- SEND sub-sequence, used for every byte:
  - Wait for ce & ispi_dsr=1.
  - Drive ospi_data and pulse ospi_wr for exactly one clk.
  - Next ce cycle is a guard cycle, ignoring dsr.
  - Then wait for ispi_dsr=1; ispi_data now holds the received byte.
  - Return to the caller state.
  - Never more than one strobe per SEND.
- FSM states:
  - IDLE: if ce & nblocks!=0, latch addr←iaddr and blk←nblocks, set ready←0 and error←0, go TOKEN. nblocks=0 means no action. nblocks changes while busy are ignored.
  - TOKEN: SEND START_TOKEN; cnt←0; go FETCH.
  - FETCH: oaddr←addr; go LATCH.
  - LATCH: on the next ce, capture idata into the byte register; go DATA.
  - DATA: SEND byte. Then addr←addr+1 (16-bit wrap, FFFF→0000) and cnt←cnt+1. If cnt reaches BLOCK_SIZE, go CRC1; else go FETCH.
  - CRC1, CRC2: SEND 8'hFF each.
  - RESP: SEND 8'hFF, up to RESP_POLLS times, until received byte bit4=0.
    - If (byte & 8'h1F)==8'h05 (accepted), go BUSY.
    - If the token is something else, or polls are exhausted, set error←1 and go DONE.
  - BUSY: SEND 8'hFF until received byte != 8'h00, then go NEXT. Exceeding BUSY_LIMIT polls sets error←1 and goes DONE.
  - NEXT: blk←blk-1. If the result is 0, go DONE; else go TOKEN. addr continues contiguously.
  - DONE: ready←1 and ospi_data←8'hFF; go IDLE.
    - A nonzero nblocks seen in the same ce cycle as DONE is not accepted; it is accepted on the following IDLE ce.
- oaddr holds its last value when idle; the bus mux selects the CPU address while ready=1.
- Counters: cnt 10-bit, poll counter 16-bit; both cleared at each use.
- ce=0 freezes the FSM except the in-flight one-clk ospi_wr deassert.
- Byte count per block on the SPI bus is exactly 1+512+2+polls.

Test Plan:
- Memory 0x0200..0x03FF = i[7:0]; nblocks=1, iaddr=0x0200; SPI model returns 0x05 on the first poll, then 0x00 ×3, then 0xFF. Required: bus sequence FE, 00..FF ×2, FF, FF; ready low throughout; error=0; 520 strobes total.
- nblocks=3, iaddr=0x7E00; card always accepts. Required: 3 packets; oaddr covers 0x7E00..0x83FF contiguously; ready returns to 1 exactly once.
- iaddr=0xFF00, nblocks=1. Required: oaddr wraps FFFF→0000 and ends at 0x00FF; no error.
- Card answers 0x0B (CRC error) after block 1 of 2. Required: error=1, only one packet sent, ready=1; next start with nblocks=1 clears error.
- Card never answers (all 0xFF). Required: exactly 8 response polls, then error=1, ready=1.
- Reset asserted during DATA byte 100. Required: ready=1 and ospi_wr=0 immediately; no strobes until a new start.
- ce toggling 1-in-4. Required: byte stream identical to the ce=1 case; every ospi_wr exactly one clk wide.
